// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchroniser.
// It filters start-bit glitches, reports framing errors, and presents each
// good byte as a one-cycle o_rx_receive strobe with o_rx_data.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic       o_rx_receive,
   output logic [7:0] o_rx_data,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_e;

   state_e           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             recv_q, recv_d;
   logic             err_q, err_d;

   // Bring the asynchronous line into the clock domain; idle level is high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State, counters, shift register and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         recv_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         recv_q    <= recv_d;
         err_q     <= err_d;
      end
   end

   // Frame sequencing: mid-bit sampling, glitch rejection, stop-bit checking.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      recv_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  recv_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_rx_receive = recv_q;
   assign o_frame_err  = err_q;
   assign o_rx_data    = data_q;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames, glitches, breaks and mid-frame resets into
// uart_rx and compares every cycle against per-cycle expectations derived
// from frame timing arithmetic, plus a few literal checkpoints.
module tb_uart_rx;

   localparam int CPB      = 16;
   localparam int HALF     = CPB / 2;
   localparam int FRAME    = 10 * CPB;
   localparam int STOP_OFS = 3 + HALF + 9 * CPB;
   localparam int MAXC     = 16384;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } pin_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       rxReceive;
   logic [7:0] rxData;
   logic       frameErr;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx        (rx),
      .o_rx_receive(rxReceive),
      .o_rx_data   (rxData),
      .o_frame_err (frameErr),
      .o_busy      (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count rising edges so expectations can be addressed by cycle number.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         expRecv[MAXC];
   bit         expErr[MAXC];
   bit         expBusy[MAXC];
   bit         expDataSet[MAXC];
   logic [7:0] expDataVal[MAXC];
   pin_t       pinQ[$];
   bit         checkEn = 1'b0;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] modelData = 8'h00;
   int         recvCount = 0;
   int         errCount = 0;
   int         lastRecvCyc = 0;
   int         prevRecvCyc = 0;
   int         pinIdx = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
      end
   endtask

   // Compare DUT outputs with the expectation tables every cycle, then any literal checkpoints due now.
   always @(negedge clk) begin
      if (checkEn && cyc < MAXC) begin
         if (expDataSet[cyc]) modelData = expDataVal[cyc];
         if (rxReceive === 1'b1) begin
            recvCount++;
            prevRecvCyc = lastRecvCyc;
            lastRecvCyc = cyc;
         end
         if (frameErr === 1'b1) errCount++;
         checkOutput("rx_receive", {31'd0, rxReceive}, {31'd0, expRecv[cyc]});
         checkOutput("frame_err", {31'd0, frameErr}, {31'd0, expErr[cyc]});
         checkOutput("busy", {31'd0, busy}, {31'd0, expBusy[cyc]});
         checkOutput("rx_data", {24'd0, rxData}, {24'd0, modelData});
         while (pinIdx < pinQ.size() && pinQ[pinIdx].cyc == cyc) begin
            case (pinQ[pinIdx].kind)
               0: checkOutput("pin_data", {24'd0, rxData}, pinQ[pinIdx].val);
               1: checkOutput("pin_recv_count", recvCount, pinQ[pinIdx].val);
               2: checkOutput("pin_err_count", errCount, pinQ[pinIdx].val);
               3: checkOutput("pin_pulse_spacing", lastRecvCyc - prevRecvCyc, pinQ[pinIdx].val);
               default: checkOutput("pin_busy", {31'd0, busy}, pinQ[pinIdx].val);
            endcase
            pinIdx++;
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setBusy(input int a, input int b);
      for (int c = a; c <= b; c++) begin
         if (c >= 0 && c < MAXC) expBusy[c] = 1'b1;
      end
   endtask

   task automatic addPin(input int kind, input int val);
      pin_t p;
      p.cyc  = cyc;
      p.kind = kind;
      p.val  = val;
      pinQ.push_back(p);
   endtask

   task automatic pinAll(input int data, input int nRecv, input int nErr);
      addPin(0, data);
      addPin(1, nRecv);
      addPin(2, nErr);
      addPin(4, 0);
   endtask

   // Send one frame; expectations come from frame start E: START at E+3,
   // stop sample at E+STOP_OFS, strobe/data visible in that cycle.
   task automatic applyStimulus(input logic [7:0] data, input bit stopOk, input int extraLow,
                                input int abortBit, input int gapAfter);
      int e;
      int s;
      int h;
      int r;
      e = cyc;
      s = e + STOP_OFS;
      if (abortBit >= 0) begin
         r = e + CPB * (1 + abortBit) + HALF;
         setBusy(e + 3, r);
         if (r + 1 < MAXC) begin
            expDataSet[r + 1] = 1'b1;
            expDataVal[r + 1] = 8'h00;
         end
      end else if (stopOk) begin
         setBusy(e + 3, s - 1);
         if (s < MAXC) begin
            expRecv[s]    = 1'b1;
            expDataSet[s] = 1'b1;
            expDataVal[s] = data;
         end
      end else begin
         h = e + FRAME + extraLow;
         setBusy(e + 3, h + 2);
         if (s < MAXC) expErr[s] = 1'b1;
      end
      rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         if (i == abortBit) begin
            waitCycles(HALF);
            rst = 1'b1;
            rx  = 1'b1;
            waitCycles(1);
            rst = 1'b0;
            waitCycles(gapAfter);
            return;
         end
         waitCycles(CPB);
      end
      rx = stopOk;
      waitCycles(CPB);
      if (!stopOk) begin
         waitCycles(extraLow);
         rx = 1'b1;
      end
      waitCycles(gapAfter);
   endtask

   // A short low pulse: START is entered at E+3 and abandoned at the E+HALF+3 sample.
   task automatic applyGlitch(input int lowLen, input int gapAfter);
      int e;
      e = cyc;
      setBusy(e + 3, e + 2 + HALF);
      rx = 1'b0;
      waitCycles(lowLen);
      rx = 1'b1;
      waitCycles(gapAfter);
   endtask

   initial begin
      int gap;
      bit ok;
      $display("[TB] uart_rx bench, CLKS_PER_BIT=%0d", CPB);
      rst = 1'b1;
      rx  = 1'b1;
      waitCycles(3);
      rst     = 1'b0;
      checkEn = 1'b1;
      addPin(0, 0);
      addPin(4, 0);
      waitCycles(5);

      applyStimulus(8'h77, 1'b1, 0, -1, 20);
      pinAll(8'h77, 1, 0);

      applyGlitch(5, 12);
      pinAll(8'h77, 1, 0);

      applyStimulus(8'h61, 1'b0, 0, -1, 1);
      applyStimulus(8'h64, 1'b1, 0, -1, 20);
      pinAll(8'h64, 2, 1);

      applyStimulus(8'h61, 1'b1, 0, -1, 0);
      applyStimulus(8'h73, 1'b1, 0, -1, 0);
      applyStimulus(8'h64, 1'b1, 0, -1, 20);
      pinAll(8'h64, 5, 1);
      addPin(3, 160);

      applyStimulus(8'h77, 1'b1, 0, 4, 20);
      pinAll(8'h00, 5, 1);

      applyStimulus(8'h73, 1'b1, 0, -1, 20);
      pinAll(8'h73, 6, 1);

      applyStimulus(8'h00, 1'b0, 40 * CPB - FRAME, -1, 20);
      pinAll(8'h73, 6, 2);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(7) == 0) begin
            applyGlitch(int'($urandom_range(5, 1)), int'($urandom_range(20, 10)));
         end else begin
            ok  = ($urandom_range(6) != 0);
            gap = ok ? int'($urandom_range(25, 0)) : int'($urandom_range(25, 1));
            applyStimulus(8'($urandom), ok, ok ? 0 : int'($urandom_range(40, 0)), -1, gap);
         end
      end

      waitCycles(20);
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
